// File: rtl/id_pkg.sv
// id_pkg: shared types, RV32I opcode constants and immediate helpers for the decode stage
package id_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // CL_NONE is the all-zero encoding so a cleared bundle reads as "no class"
    typedef enum logic [3:0] {
        CL_NONE, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH,
        CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_SYSTEM
    } op_class_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        op_class_e   op_class;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        br_pred;
        logic        illegal;
    } decoded_t;

    typedef struct packed {
        logic     valid;
        decoded_t dec;
    } stage_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: one pending-write bit per register with a RAW/WAW hazard query
module id_scoreboard #(
    parameter int N_REGS = 32
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       clr_en,
    input  logic [4:0] clr_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic       use_rd,
    output logic       hazard
);
    logic [N_REGS-1:0] pending_q, set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_mask[set_rd] = set_en;
        clr_mask[clr_rd] = clr_en;
    end

    // bit 0 is masked so x0 can never look pending
    always_ff @(posedge clk)
        if (rst_i) pending_q <= '0;
        else pending_q <= ((pending_q & ~clr_mask) | set_mask) & {{(N_REGS-1){1'b1}}, 1'b0};

    assign hazard = (use_rs1 & pending_q[rs1]) | (use_rs2 & pending_q[rs2]) | (use_rd & pending_q[rd]);
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage; decodes, reads operands, tracks pending writes
// and holds one registered decoded bundle for execute.
module id_stage
    import id_pkg::*;
#(
    parameter int N_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        halt_i,
    input  logic        valid_i,
    output logic        ack_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        br_pred_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        wb_clr_i,
    input  logic [4:0]  wb_rd_i,
    output logic        valid_o,
    input  logic        ack_i,
    output decoded_t    dec_o
);
    op_class_e  cls;
    alu_op_e    arith;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       uses_rs1, uses_rs2, writes_rd, hazard;
    decoded_t   dec_d;
    stage_t     data_q;

    assign opc        = instr_i[6:0];
    assign f3         = instr_i[14:12];
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    always_comb begin
        dec_d = '0;
        cls = opc == OPC_LUI    ? CL_LUI    :
              opc == OPC_AUIPC  ? CL_AUIPC  :
              opc == OPC_JAL    ? CL_JAL    :
              opc == OPC_JALR   ? CL_JALR   :
              opc == OPC_BRANCH ? CL_BRANCH :
              opc == OPC_LOAD   ? CL_LOAD   :
              opc == OPC_STORE  ? CL_STORE  :
              opc == OPC_OPIMM  ? CL_OPIMM  :
              opc == OPC_OP     ? CL_OP     :
              opc == OPC_SYSTEM ? CL_SYSTEM : CL_NONE;
        uses_rs1  = cls inside {CL_JALR, CL_BRANCH, CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_SYSTEM};
        uses_rs2  = cls inside {CL_BRANCH, CL_STORE, CL_OP};
        writes_rd = !(cls inside {CL_NONE, CL_BRANCH, CL_STORE});
        // instr[30] selects SUB only for register-register ops; shifts use it for both
        arith = f3 == 3'd0 ? ((cls == CL_OP && instr_i[30]) ? ALU_SUB : ALU_ADD) :
                f3 == 3'd1 ? ALU_SLL  :
                f3 == 3'd2 ? ALU_SLT  :
                f3 == 3'd3 ? ALU_SLTU :
                f3 == 3'd4 ? ALU_XOR  :
                f3 == 3'd5 ? (instr_i[30] ? ALU_SRA : ALU_SRL) :
                f3 == 3'd6 ? ALU_OR   : ALU_AND;
        dec_d.pc       = pc_i;
        dec_d.rs1_data = (uses_rs1 && rs1_addr_o != '0) ? rs1_data_i : '0;
        dec_d.rs2_data = (uses_rs2 && rs2_addr_o != '0) ? rs2_data_i : '0;
        dec_d.imm      = cls inside {CL_LUI, CL_AUIPC} ? imm_u(instr_i) :
                         cls == CL_JAL    ? imm_j(instr_i) :
                         cls == CL_BRANCH ? imm_b(instr_i) :
                         cls == CL_STORE  ? imm_s(instr_i) :
                         cls inside {CL_JALR, CL_LOAD, CL_OPIMM, CL_SYSTEM} ? imm_i(instr_i) : '0;
        dec_d.rd       = writes_rd ? instr_i[11:7] : '0;
        dec_d.op_class = cls;
        dec_d.funct3   = uses_rs1 ? f3 : '0;
        dec_d.alu_op   = cls inside {CL_OP, CL_OPIMM} ? arith : cls == CL_LUI ? ALU_PASSB : ALU_ADD;
        dec_d.br_pred  = br_pred_i;
        dec_d.illegal  = cls == CL_NONE;
    end

    id_scoreboard #(.N_REGS(N_REGS)) u_sb (
        .clk     (clk),
        .rst_i   (rst_i),
        .set_en  (ack_o & writes_rd),
        .set_rd  (dec_d.rd),
        .clr_en  (wb_clr_i),
        .clr_rd  (wb_rd_i),
        .rs1     (rs1_addr_o),
        .rs2     (rs2_addr_o),
        .rd      (dec_d.rd),
        .use_rs1 (uses_rs1),
        .use_rs2 (uses_rs2),
        .use_rd  (writes_rd),
        .hazard  (hazard)
    );

    assign ack_o = valid_i & (~data_q.valid | ack_i) & ~hazard & ~halt_i & ~flush_i & ~rst_i;

    always_ff @(posedge clk)
        if (rst_i) data_q <= '0;
        else if (ack_o) data_q <= '{valid: 1'b1, dec: dec_d};
        else if (ack_i | flush_i) data_q.valid <= 1'b0;

    assign valid_o = data_q.valid;
    assign dec_o   = data_q.dec;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized bench for id_stage; a spec-level decode/scoreboard model
// queues expected bundles and a monitor compares them as execute consumes them.
`timescale 1ns/1ps
module tb_id_stage;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, halt_i, valid_i, ack_o, br_pred_i, wb_clr_i, valid_o, ack_i;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o, wb_rd_i;
    decoded_t    dec_o;

    always #5 clk = ~clk;

    id_stage #(.N_REGS(32)) dut (
        .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .halt_i(halt_i),
        .valid_i(valid_i), .ack_o(ack_o), .instr_i(instr_i), .pc_i(pc_i),
        .br_pred_i(br_pred_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wb_clr_i(wb_clr_i),
        .wb_rd_i(wb_rd_i), .valid_o(valid_o), .ack_i(ack_i), .dec_o(dec_o)
    );

    logic [31:0] regs [32];
    assign rs1_data_i = regs[rs1_addr_o];
    assign rs2_data_i = regs[rs2_addr_o];

    int       checks = 0, errors = 0;
    decoded_t exp_q[$];
    bit       pend [32];
    bit       m_valid = 1'b0;
    bit       acc;

    function automatic void chk(string nm, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic op_class_e ref_class(logic [6:0] o);
        case (o)
            7'h37: return CL_LUI;
            7'h17: return CL_AUIPC;
            7'h6F: return CL_JAL;
            7'h67: return CL_JALR;
            7'h63: return CL_BRANCH;
            7'h03: return CL_LOAD;
            7'h23: return CL_STORE;
            7'h13: return CL_OPIMM;
            7'h33: return CL_OP;
            7'h73: return CL_SYSTEM;
            default: return CL_NONE;
        endcase
    endfunction

    function automatic bit reads1(op_class_e c);
        return c inside {CL_JALR, CL_BRANCH, CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_SYSTEM};
    endfunction

    function automatic bit reads2(op_class_e c);
        return c inside {CL_BRANCH, CL_STORE, CL_OP};
    endfunction

    function automatic bit writes(op_class_e c);
        return c != CL_NONE && c != CL_BRANCH && c != CL_STORE;
    endfunction

    // immediates rebuilt by weighting fields and subtracting the sign bit's weight
    function automatic logic [31:0] ref_imm(logic [31:0] ir);
        int v;
        case (ref_class(ir[6:0]))
            CL_LUI, CL_AUIPC: v = int'(ir & 32'hFFFFF000);
            CL_JAL:    v = int'(ir[30:21]) * 2 + int'(ir[20]) * 2048 + int'(ir[19:12]) * 4096 - int'(ir[31]) * (1 << 20);
            CL_BRANCH: v = int'(ir[11:8]) * 2 + int'(ir[30:25]) * 32 + int'(ir[7]) * 2048 - int'(ir[31]) * 4096;
            CL_STORE:  v = int'(ir[30:25]) * 32 + int'(ir[11:7]) - int'(ir[31]) * 2048;
            CL_JALR, CL_LOAD, CL_OPIMM, CL_SYSTEM: v = int'(ir[30:20]) - int'(ir[31]) * 2048;
            default:   v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic alu_op_e ref_alu(logic [31:0] ir);
        op_class_e c = ref_class(ir[6:0]);
        if (c == CL_LUI) return ALU_PASSB;
        if (c != CL_OP && c != CL_OPIMM) return ALU_ADD;
        case (ir[14:12])
            3'd0: return (c == CL_OP && ir[30]) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return ir[30] ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic decoded_t ref_decode(logic [31:0] ir, logic [31:0] pc, logic pred);
        decoded_t  d;
        op_class_e c = ref_class(ir[6:0]);
        d.pc       = pc;
        d.rs1_data = (reads1(c) && ir[19:15] != 0) ? regs[ir[19:15]] : 32'h0;
        d.rs2_data = (reads2(c) && ir[24:20] != 0) ? regs[ir[24:20]] : 32'h0;
        d.imm      = ref_imm(ir);
        d.rd       = writes(c) ? ir[11:7] : 5'h0;
        d.op_class = c;
        d.funct3   = reads1(c) ? ir[14:12] : 3'h0;
        d.alu_op   = ref_alu(ir);
        d.br_pred  = pred;
        d.illegal  = c == CL_NONE;
        return d;
    endfunction

    function automatic bit ref_hazard(logic [31:0] ir);
        op_class_e c = ref_class(ir[6:0]);
        return (reads1(c) && pend[ir[19:15]]) || (reads2(c) && pend[ir[24:20]]) || (writes(c) && pend[ir[11:7]]);
    endfunction

    // reference model: predicts ack_o/valid_o, then advances to the state after the next edge
    initial forever begin
        bit eack;
        @(negedge clk);
        eack = !rst_i && valid_i && (!m_valid || ack_i) && !ref_hazard(instr_i) && !halt_i && !flush_i;
        chk("ack_o", ack_o, eack);
        chk("valid_o", valid_o, m_valid);
        if (rst_i) begin
            m_valid = 1'b0;
            foreach (pend[i]) pend[i] = 1'b0;
        end else begin
            if (wb_clr_i) pend[wb_rd_i] = 1'b0;
            if (eack) begin
                exp_q.push_back(ref_decode(instr_i, pc_i, br_pred_i));
                m_valid = 1'b1;
                if (writes(ref_class(instr_i[6:0])) && instr_i[11:7] != 0) pend[instr_i[11:7]] = 1'b1;
            end else if (ack_i || flush_i) m_valid = 1'b0;
        end
    end

    // monitor: compares each bundle execute consumes; squashed bundles are discarded
    initial forever begin
        @(negedge clk);
        if (valid_o && ack_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dec_o: got %0h with no bundle expected", dec_o);
            end else chk("dec_o", dec_o, exp_q.pop_front());
        end else if (valid_o && (flush_i || rst_i) && exp_q.size() != 0) void'(exp_q.pop_front());
    end

    task automatic drive(bit v, logic [31:0] ir, bit a, bit fl, bit h, bit clr, logic [4:0] crd, bit r);
        valid_i = v; instr_i = ir; ack_i = a; flush_i = fl; halt_i = h;
        wb_clr_i = clr; wb_rd_i = crd; rst_i = r;
        pc_i = $urandom & 32'hFFFFFFFC;
        br_pred_i = 1'($urandom);
        @(negedge clk);
        acc = ack_o;
        @(posedge clk);
        #1;
        if (clr && crd != 0 && !r) regs[crd] = $urandom;
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [31:0] x = 32'(imm);
        return {x[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
        logic [31:0] x = 32'(imm);
        return {x[12], x[10:5], 5'(rs2), 5'(rs1), 3'b000, x[4:1], x[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] x = 32'(imm);
        return {x[20], x[10:1], x[11], x[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops [10];
        logic [31:0] ir = $urandom;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        // few registers so RAW/WAW hazards are common
        ir[11:7]  = 5'($urandom_range(0, 7));
        ir[19:15] = 5'($urandom_range(0, 7));
        ir[24:20] = 5'($urandom_range(0, 7));
        ir[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
        return ir;
    endfunction

    initial begin
        logic [31:0] raw, ir;
        foreach (regs[i]) regs[i] = $urandom | 32'h1;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset valid_o", valid_o, 0);
        chk("reset dec_o", dec_o, 0);

        drive(1, enc_i(5, 0, 0, 1, 7'h13), 1, 0, 0, 0, 0, 0);
        chk("b2b first imm", dec_o.imm, 5);
        drive(1, enc_i(7, 0, 0, 2, 7'h13), 1, 0, 0, 0, 0, 0);
        chk("b2b second imm", dec_o.imm, 7);
        drive(1, enc_i(3, 0, 0, 2, 7'h13), 1, 0, 0, 0, 0, 0);
        chk("waw stall", valid_o, 0);
        raw = enc_r(0, 1, 1, 0, 3);
        drive(1, raw, 1, 0, 0, 0, 0, 0);
        drive(1, raw, 1, 0, 0, 1, 1, 0);
        drive(1, raw, 1, 0, 0, 1, 2, 0);
        chk("raw rs1_data", dec_o.rs1_data, regs[1]);
        drive(0, 0, 1, 0, 0, 1, 3, 0);

        drive(1, enc_i(9, 0, 0, 4, 7'h13), 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, enc_i(1, 0, 0, 5, 7'h13), 0, 0, 0, 0, 0, 0);
            chk("backpressure hold imm", dec_o.imm, 9);
        end
        drive(1, enc_i(1, 0, 0, 5, 7'h13), 1, 0, 0, 0, 0, 0);
        chk("release accept imm", dec_o.imm, 1);
        drive(1, enc_i(2, 0, 0, 6, 7'h13), 0, 1, 0, 0, 0, 0);
        chk("flush clears valid", valid_o, 0);
        drive(0, 0, 0, 0, 0, 1, 4, 0);
        drive(0, 0, 0, 0, 0, 1, 5, 0);

        drive(1, enc_b(-8, 0, 0), 1, 0, 0, 0, 0, 0);
        chk("beq imm", dec_o.imm, 32'hFFFFFFF8);
        drive(1, enc_j(32'h800, 7), 1, 0, 0, 0, 0, 0);
        chk("jal imm", dec_o.imm, 32'h00000800);
        drive(1, 32'h12345FFF, 1, 0, 0, 0, 0, 0);
        chk("illegal flag", dec_o.illegal, 1);
        chk("illegal rd", dec_o.rd, 0);
        drive(1, enc_r(0, 0, 5, 0, 0), 1, 0, 0, 1, 7, 0);
        drive(1, enc_r(0, 0, 0, 0, 8), 1, 0, 0, 0, 0, 0);
        chk("x0 rs1 read", dec_o.rs1_data, 0);
        chk("x0 rs2 read", dec_o.rs2_data, 0);
        drive(0, 0, 1, 0, 0, 1, 8, 0);

        drive(1, enc_i(1, 0, 0, 1, 7'h13), 0, 0, 0, 0, 0, 0);
        drive(1, raw, 0, 0, 0, 0, 0, 0);
        drive(1, raw, 0, 0, 0, 0, 0, 1);
        chk("stalled reset valid_o", valid_o, 0);
        chk("stalled reset dec_o", dec_o, 0);
        drive(1, raw, 1, 0, 0, 0, 0, 0);
        chk("post-reset accept", valid_o, 1);
        drive(0, 0, 1, 0, 0, 1, 3, 0);

        ir = rnd_instr();
        for (int n = 0; n < 4000; n++) begin
            int   plist[$];
            bit   clr;
            logic [4:0] crd;
            foreach (pend[i]) if (pend[i]) plist.push_back(i);
            clr = $urandom_range(0, 9) < 3;
            crd = (plist.size() != 0) ? 5'(plist[$urandom_range(0, plist.size() - 1)]) : 5'd0;
            drive($urandom_range(0, 9) < 8, ir, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0, clr, crd, $urandom_range(0, 499) == 0);
            if (acc) ir = rnd_instr();
        end

        for (int k = 0; k < 4; k++) drive(0, 0, 1, 0, 0, 0, 0, 0);
        chk("drained queue", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# ID_stage

Instruction-decode stage of the pipelined RV32I core. Sits directly downstream of the instruction-fetch stage and upstream of execute. It:
- accepts one fetched instruction per cycle over a valid/ack handshake;
- decodes it, reads both source operands from the register file and tracks outstanding register writes in a scoreboard;
- presents a registered, decoded bundle to execute.

## Interface
Parameters:
- `N_REGS`, 32: architectural registers; x0 is hard-wired zero.

Ports:
- `clk`  in  1  core clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  squash the held bundle (branch taken / exception).
- `halt_i`  in  1  debug halt; no new acceptance.
- `valid_i`  in  1  fetch stage holds a valid instruction.
- `ack_o`  out  1  instruction accepted this cycle.
- `instr_i`  in  32  instruction word.
- `pc_i`  in  32  instruction address.
- `br_pred_i`  in  1  fetch predicted this instruction taken.
- `rs1_addr_o`, `rs2_addr_o`  out  5  combinational register-file read addresses.
- `rs1_data_i`, `rs2_data_i`  in  32  combinational register-file read data.
- `wb_clr_i`  in  1  downstream retires or squashes an instruction that set a scoreboard bit.
- `wb_rd_i`  in  5  register whose pending bit is cleared.
- `valid_o`  out  1  decoded bundle valid.
- `ack_i`  in  1  execute consumed the bundle.
- `dec_o`  out  `id_pkg::decoded_t`  pc, rs1/rs2 data, imm, rd, op class, funct3, alu op, br_pred, illegal.

## Operation
- Holding register `data_q` carries the valid bit plus `decoded_t`; all outputs are driven from `data_q`.
- Decode is combinational on `instr_i`:
  - classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM;
  - immediates I/S/B/U/J are sign-extended to 32 bits;
  - any other opcode sets `illegal`, with rd forced to 0.
- `uses_rs1` / `uses_rs2` / `writes_rd` come from the op class.
- Hazard = (`uses_rs1` & pending[rs1]) | (`uses_rs2` & pending[rs2]) | (`writes_rd` & pending[rd]). The rd term is the WAW stall.
- `ack_o` = `valid_i` & (!`valid_o` | `ack_i`) & !hazard & !`halt_i` & !`flush_i`.
- On `ack_o`, `data_q` loads the decoded bundle with valid=1, and pending[rd] is set if `writes_rd` and rd≠0.
- Else if `ack_i`, valid clears. Otherwise `data_q` holds.
- `flush_i` clears valid, blocks acceptance and never sets a pending bit. It does not touch the scoreboard; downstream must issue `wb_clr_i` for every squashed writer.
- `wb_clr_i` clears pending[`wb_rd_i`] at the next edge. pending[0] is always 0.
- Reads of x0 return 0 regardless of `rs*_data_i`.

## Timing
- Reset: `valid_o`=0, `ack_o`=0 (combinationally, while `rst_i`), `dec_o`=0, all pending bits 0. Reset mid-handshake drops the held bundle.
- Latency: accept at edge N gives `valid_o` from cycle N+1. Throughput is 1/cycle with no hazards.
- `valid_o` and `dec_o` are stable until `ack_i`. A new accept in the same cycle as `ack_i` is allowed (back-to-back).
- There is no writeback bypass:
  - a `wb_clr_i` in cycle N unblocks a dependent instruction in cycle N+1 at the earliest;
  - the register file must have written by then.
- Same-cycle set and clear on one register cannot occur, because a pending rd stalls issue. An erroneous clear of a non-pending register is a no-op.
- `flush_i` together with `ack_i` leaves valid cleared. `flush_i` together with `wb_clr_i` still applies the clear.

## Structure
- `id_pkg` holds:
  - `decoded_t`;
  - op-class enum;
  - ALU-op enum;
  - RV32I opcode constants;
  - immediate-format functions.
- Sub-module `id_scoreboard` holds the N_REGS-bit pending vector, with set port, clear port and two-read-plus-rd hazard query.
- Decode stays inline in `ID_stage`.

## Test plan
- **Back-to-back, no hazard:** stream `addi x1,x0,5` then `addi x2,x0,7` with `ack_i`=1 → `ack_o` high both cycles; `valid_o` from cycle+1; imm 5 then 7; pending = {x1,x2}.
- **RAW stall:** `addi x1,x0,1` then `add x3,x1,x1` → `ack_o`=0 until one cycle after `wb_clr_i`/`wb_rd_i`=1; the bundle then carries `rs1_data_i`.
- **Backpressure:** `ack_i`=0 for 3 cycles with `valid_i`=1 → `dec_o` unchanged, `ack_o`=0; release → next instruction accepted on the same edge.
- **Flush:** `flush_i` with valid bundle and pending `valid_i` → next cycle `valid_o`=0, no new pending bit; pending bits only clear through `wb_clr_i`.
- **Immediates/illegal:** `beq` offset −8 gives imm 0xFFFFFFF8; `jal` offset 0x800 gives 0x00000800; opcode 0x7F gives illegal=1, rd=0, pending unchanged.
- **x0 and reset:** `add x0,x5,x0` never sets pending; x0 reads return 0. Assert `rst_i` while stalled → all outputs 0 and scoreboard empty on the following cycle.
